pll_cfg_sequencer: RTL and testbench



---
 rtl/pll_cfg_sequencer_pkg.sv | 33 +++
 rtl/pll_cfg_sequencer_if.sv | 23 ++
 rtl/pll_cfg_sequencer_lock_sync.sv | 20 ++
 rtl/pll_cfg_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pll_cfg_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pll_cfg_sequencer_pkg.sv
// Shared state, divider types and constants for the PLL configuration sequencer.
package pll_cfg_pkg;

   localparam int unsigned FBDIV_MIN = 16;
   localparam int unsigned FBDIV_W   = 12;
   localparam int unsigned REFDIV_W  = 6;
   localparam int unsigned POSTDIV_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PWRDN,
      ST_PROGRAM,
      ST_WAIT_LOCK,
      ST_LOCKED,
      ST_ERROR
   } pll_state_e;

   typedef struct packed {
      logic [FBDIV_W-1:0]   fbdiv;
      logic [REFDIV_W-1:0]  refdiv;
      logic [POSTDIV_W-1:0] postdiv1;
      logic [POSTDIV_W-1:0] postdiv2;
   } pll_div_t;

   function automatic logic div_legal(input pll_div_t d);
      return (d.fbdiv >= FBDIV_W'(FBDIV_MIN)) &&
             (d.refdiv != '0) &&
             (d.postdiv1 != '0) &&
             (d.postdiv2 != '0) &&
             (d.postdiv1 >= d.postdiv2);
   endfunction

endpackage

// File: rtl/pll_cfg_sequencer_if.sv
// Valid/ready configuration request bus from the APB register block.
interface pll_cfg_if;
   import pll_cfg_pkg::*;

   logic                 cfg_valid;
   logic                 cfg_ready;
   logic                 cfg_pd;
   logic [FBDIV_W-1:0]   cfg_fbdiv;
   logic [REFDIV_W-1:0]  cfg_refdiv;
   logic [POSTDIV_W-1:0] cfg_postdiv1;
   logic [POSTDIV_W-1:0] cfg_postdiv2;

   modport master (
      output cfg_valid, cfg_pd, cfg_fbdiv, cfg_refdiv, cfg_postdiv1, cfg_postdiv2,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_pd, cfg_fbdiv, cfg_refdiv, cfg_postdiv1, cfg_postdiv2,
      output cfg_ready
   );

endinterface

// File: rtl/pll_cfg_sequencer_lock_sync.sv
// Synchronizer chain bringing the asynchronous PLL lock indication onto clk.
module pll_lock_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_chain <= '0;
      else        r_chain <= {r_chain[STAGES-2:0], i_async};
   end

   assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/pll_cfg_sequencer.sv
// PLL power-down / program / lock sequencer with clock-select hand-off.
// Optional build macro PLL_LOCK_RETRY_EN: retry lock up to MAX_RETRY attempts.
module pll_cfg_sequencer
   import pll_cfg_pkg::*;
#(
   parameter int unsigned          PD_CYCLES    = 16,
   parameter int unsigned          LOCK_TIMEOUT = 4096,
   parameter int unsigned          LOCK_SYNC    = 2,
   parameter logic [FBDIV_W-1:0]   RST_FBDIV    = 12'd50,
   parameter logic [REFDIV_W-1:0]  RST_REFDIV   = 6'd1,
   parameter int unsigned          MAX_RETRY    = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pll_cfg_if.slave             cfg,
   input  logic                 pll_lock,
   output logic                 pll_pd,
   output logic                 pll_bypass,
   output logic                 pll_foutvcopd,
   output logic                 pll_foutpostdivpd,
   output logic                 pll_dsmpd,
   output logic [FBDIV_W-1:0]   pll_fbdiv,
   output logic [REFDIV_W-1:0]  pll_refdiv,
   output logic [POSTDIV_W-1:0] pll_postdiv1,
   output logic [POSTDIV_W-1:0] pll_postdiv2,
   output logic                 clk_sel,
   output logic                 sts_locked,
   output logic                 sts_err,
   output logic                 irq
);

   localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > PD_CYCLES) ? LOCK_TIMEOUT : PD_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

   generate
      if (PD_CYCLES < 2 || LOCK_SYNC < 2 || MAX_RETRY < 1) begin : g_bad_param
         $error("pll_cfg_sequencer: PD_CYCLES>=2, LOCK_SYNC>=2, MAX_RETRY>=1 required");
      end
   endgenerate

   pll_state_e       r_state;
   logic             r_ready;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pd_req;
   logic             r_pd;
   logic             r_bypass;
   logic             r_vcopd;
   logic             r_postdivpd;
   pll_div_t         r_div;
   logic             r_clk_sel;
   logic             r_locked;
   logic             r_err;
   logic             r_irq;

`ifdef PLL_LOCK_RETRY_EN
   localparam int unsigned TRY_W = $clog2(MAX_RETRY) + 1;
   localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_RETRY - 1);
   logic [TRY_W-1:0] r_try;
`endif

   logic     w_lock_s;
   logic     w_accept;
   logic     w_legal;
   pll_div_t w_req;

   pll_lock_sync #(.STAGES(LOCK_SYNC)) u_lock_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (pll_lock),
      .o_sync  (w_lock_s)
   );

   assign w_req    = '{fbdiv: cfg.cfg_fbdiv, refdiv: cfg.cfg_refdiv,
                       postdiv1: cfg.cfg_postdiv1, postdiv2: cfg.cfg_postdiv2};
   assign w_legal  = div_legal(w_req);
   assign w_accept = cfg.cfg_valid & r_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ready     <= 1'b1;
         r_cnt       <= '0;
         r_pd_req    <= 1'b0;
         r_pd        <= 1'b1;
         r_bypass    <= 1'b1;
         r_vcopd     <= 1'b1;
         r_postdivpd <= 1'b1;
         r_div       <= '{fbdiv: RST_FBDIV, refdiv: RST_REFDIV,
                          postdiv1: POSTDIV_W'(1), postdiv2: POSTDIV_W'(1)};
         r_clk_sel   <= 1'b0;
         r_locked    <= 1'b0;
         r_err       <= 1'b0;
         r_irq       <= 1'b0;
`ifdef PLL_LOCK_RETRY_EN
         r_try       <= '0;
`endif
      end else begin
         r_irq <= 1'b0;
         // An accepted request pre-empts everything, including a same-cycle lock loss.
         if (w_accept) begin
            r_err       <= 1'b0;
            r_clk_sel   <= 1'b0;
            r_bypass    <= 1'b1;
            r_locked    <= 1'b0;
            r_pd        <= 1'b1;
            r_vcopd     <= 1'b1;
            r_postdivpd <= 1'b1;
            r_cnt       <= '0;
`ifdef PLL_LOCK_RETRY_EN
            r_try       <= '0;
`endif
            if (cfg.cfg_pd) begin
               r_state  <= ST_PWRDN;
               r_ready  <= 1'b0;
               r_pd_req <= 1'b1;
            end else if (!w_legal) begin
               r_state  <= ST_ERROR;
               r_err    <= 1'b1;
               r_irq    <= 1'b1;
            end else begin
               r_state  <= ST_PWRDN;
               r_ready  <= 1'b0;
               r_pd_req <= 1'b0;
               r_div    <= w_req;
            end
         end else begin
            unique case (r_state)
               ST_PWRDN: begin
                  if (r_cnt == PD_LAST) begin
                     r_cnt <= '0;
                     if (r_pd_req) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                     end else begin
                        r_state     <= ST_PROGRAM;
                        r_pd        <= 1'b0;
                        r_postdivpd <= 1'b0;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_PROGRAM: begin
                  r_state <= ST_WAIT_LOCK;
                  r_cnt   <= '0;
               end
               ST_WAIT_LOCK: begin
                  if (w_lock_s) begin
                     r_state  <= ST_LOCKED;
                     r_ready  <= 1'b1;
                     r_bypass <= 1'b0;
                     r_locked <= 1'b1;
                     r_irq    <= 1'b1;
                  end else if (r_cnt == TO_LAST) begin
                     r_cnt       <= '0;
                     r_pd        <= 1'b1;
                     r_vcopd     <= 1'b1;
                     r_postdivpd <= 1'b1;
`ifdef PLL_LOCK_RETRY_EN
                     if (r_try != TRY_LAST) begin
                        r_try   <= r_try + 1'b1;
                        r_state <= ST_PWRDN;
                     end else
`endif
                     begin
                        r_state <= ST_ERROR;
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                        r_irq   <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_LOCKED: begin
                  // clk_sel follows bypass release by one cycle so the mux never sees an unlocked PLL.
                  if (!w_lock_s) begin
                     r_state   <= ST_WAIT_LOCK;
                     r_ready   <= 1'b0;
                     r_cnt     <= '0;
                     r_clk_sel <= 1'b0;
                     r_bypass  <= 1'b1;
                     r_locked  <= 1'b0;
                  end else begin
                     r_clk_sel <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign cfg.cfg_ready     = r_ready;
   assign pll_pd            = r_pd;
   assign pll_bypass        = r_bypass;
   assign pll_foutvcopd     = r_vcopd;
   assign pll_foutpostdivpd = r_postdivpd;
   assign pll_dsmpd         = 1'b1;
   assign pll_fbdiv         = r_div.fbdiv;
   assign pll_refdiv        = r_div.refdiv;
   assign pll_postdiv1      = r_div.postdiv1;
   assign pll_postdiv2      = r_div.postdiv2;
   assign clk_sel           = r_clk_sel;
   assign sts_locked        = r_locked;
   assign sts_err           = r_err;
   assign irq               = r_irq;

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Directed self-checking bench for pll_cfg_sequencer (short LOCK_TIMEOUT instance).
module tb_pll_cfg_sequencer;

   localparam int unsigned PD_CYC  = 16;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned SYNC    = 2;
   localparam int unsigned RETRY   = 3;
`ifdef PLL_LOCK_RETRY_EN
   localparam int unsigned TO_EXP = (TIMEOUT + 1) + (RETRY - 1) * (PD_CYC + 1 + TIMEOUT);
`else
   localparam int unsigned TO_EXP = TIMEOUT + 1;
`endif

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        pll_lock = 1'b0;
   logic        pll_pd, pll_bypass, pll_foutvcopd, pll_foutpostdivpd, pll_dsmpd;
   logic [11:0] pll_fbdiv;
   logic [5:0]  pll_refdiv;
   logic [2:0]  pll_postdiv1, pll_postdiv2;
   logic        clk_sel, sts_locked, sts_err, irq;

   int checks   = 0;
   int failures = 0;
   int irq_n    = 0;
   int n, m, n0;

   pll_cfg_if u_if ();

   pll_cfg_sequencer #(
      .PD_CYCLES    (PD_CYC),
      .LOCK_TIMEOUT (TIMEOUT),
      .LOCK_SYNC    (SYNC),
      .RST_FBDIV    (12'd50),
      .RST_REFDIV   (6'd1),
      .MAX_RETRY    (RETRY)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cfg               (u_if),
      .pll_lock          (pll_lock),
      .pll_pd            (pll_pd),
      .pll_bypass        (pll_bypass),
      .pll_foutvcopd     (pll_foutvcopd),
      .pll_foutpostdivpd (pll_foutpostdivpd),
      .pll_dsmpd         (pll_dsmpd),
      .pll_fbdiv         (pll_fbdiv),
      .pll_refdiv        (pll_refdiv),
      .pll_postdiv1      (pll_postdiv1),
      .pll_postdiv2      (pll_postdiv2),
      .clk_sel           (clk_sel),
      .sts_locked        (sts_locked),
      .sts_err           (sts_err),
      .irq               (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (irq === 1'b1) irq_n++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic pd, input logic [11:0] fb, input logic [5:0] rd,
                       input logic [2:0] p1, input logic [2:0] p2);
      u_if.cfg_valid    = 1'b1;
      u_if.cfg_pd       = pd;
      u_if.cfg_fbdiv    = fb;
      u_if.cfg_refdiv   = rd;
      u_if.cfg_postdiv1 = p1;
      u_if.cfg_postdiv2 = p2;
      @(negedge clk);
      u_if.cfg_valid    = 1'b0;
   endtask

   initial begin
      u_if.cfg_valid    = 1'b0;
      u_if.cfg_pd       = 1'b0;
      u_if.cfg_fbdiv    = '0;
      u_if.cfg_refdiv   = '0;
      u_if.cfg_postdiv1 = '0;
      u_if.cfg_postdiv2 = '0;

      // Reset state
      cycles(2);
      chk("rst_pd",        32'(pll_pd), 1);
      chk("rst_bypass",    32'(pll_bypass), 1);
      chk("rst_vcopd",     32'(pll_foutvcopd), 1);
      chk("rst_postdivpd", 32'(pll_foutpostdivpd), 1);
      chk("rst_dsmpd",     32'(pll_dsmpd), 1);
      chk("rst_fbdiv",     32'(pll_fbdiv), 50);
      chk("rst_refdiv",    32'(pll_refdiv), 1);
      chk("rst_postdiv1",  32'(pll_postdiv1), 1);
      chk("rst_postdiv2",  32'(pll_postdiv2), 1);
      chk("rst_clk_sel",   32'(clk_sel), 0);
      chk("rst_sts",       32'({sts_locked, sts_err, irq}), 0);
      chk("rst_ready",     32'(u_if.cfg_ready), 1);

      rst_n = 1'b1;
      cycles(20);
      chk("idle_pd",      32'(pll_pd), 1);
      chk("idle_bypass",  32'(pll_bypass), 1);
      chk("idle_clk_sel", 32'(clk_sel), 0);
      chk("idle_fbdiv",   32'(pll_fbdiv), 50);
      chk("idle_ready",   32'(u_if.cfg_ready), 1);

      // Legal request, lock arrives 40 cycles after pd falls
      send(1'b0, 12'd100, 6'd2, 3'd2, 3'd1);
      chk("leg_fbdiv",  32'(pll_fbdiv), 100);
      chk("leg_refdiv", 32'(pll_refdiv), 2);
      chk("leg_pdivs",  32'({pll_postdiv1, pll_postdiv2}), 32'({3'd2, 3'd1}));
      chk("leg_ready",  32'(u_if.cfg_ready), 0);
      n = 0;
      while (pll_pd === 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("leg_pd_high_cycles", 32'(n), PD_CYC);
      chk("prog_postdivpd", 32'(pll_foutpostdivpd), 0);
      chk("prog_vcopd",     32'(pll_foutvcopd), 1);
      chk("prog_bypass",    32'(pll_bypass), 1);
      cycles(40);
      pll_lock = 1'b1;
      m = 0;
      while (pll_bypass === 1'b1 && m < 50) begin @(negedge clk); m++; end
      chk("lock_to_bypass_window", 32'(m >= SYNC && m <= SYNC + 2), 1);
      chk("lock_irq",        32'(irq), 1);
      chk("lock_sts_locked", 32'(sts_locked), 1);
      chk("lock_clk_sel_lag", 32'(clk_sel), 0);
      chk("lock_ready",      32'(u_if.cfg_ready), 1);
      cycles(1);
      chk("lock_clk_sel", 32'(clk_sel), 1);
      chk("lock_irq_one", 32'(irq), 0);
      chk("lock_bypass",  32'(pll_bypass), 0);

      // Lock loss for 10 cycles, then relock
      n0 = irq_n;
      pll_lock = 1'b0;
      m = 0;
      while (clk_sel === 1'b1 && m < 50) begin @(negedge clk); m++; end
      chk("loss_latency_ok", 32'(m >= 1 && m <= SYNC + 1), 1);
      chk("loss_bypass",     32'(pll_bypass), 1);
      chk("loss_sts_locked", 32'(sts_locked), 0);
      chk("loss_pd_stays",   32'(pll_pd), 0);
      cycles(10 - m);
      chk("loss_no_irq", 32'(irq_n), 32'(n0));
      pll_lock = 1'b1;
      m = 0;
      while (clk_sel !== 1'b1 && m < 50) begin @(negedge clk); m++; end
      chk("relock_clk_sel", 32'(clk_sel), 1);
      chk("relock_locked",  32'(sts_locked), 1);
      chk("relock_irq_one", 32'(irq_n), 32'(n0 + 1));

      // Power-down request while LOCKED
      send(1'b1, 12'd0, 6'd0, 3'd0, 3'd0);
      chk("pdreq_clk_sel", 32'(clk_sel), 0);
      chk("pdreq_bypass",  32'(pll_bypass), 1);
      chk("pdreq_pd",      32'(pll_pd), 1);
      chk("pdreq_locked",  32'(sts_locked), 0);
      chk("pdreq_ready",   32'(u_if.cfg_ready), 0);
      pll_lock = 1'b0;
      n = 0;
      while (u_if.cfg_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("pdreq_idle_cycles", 32'(n), PD_CYC);
      chk("pdreq_idle_pd",     32'(pll_pd), 1);
      chk("pdreq_fbdiv_kept",  32'(pll_fbdiv), 100);

      // Illegal: fbdiv below minimum
      send(1'b0, 12'd15, 6'd2, 3'd2, 3'd1);
      chk("ill_fb_err",   32'(sts_err), 1);
      chk("ill_fb_irq",   32'(irq), 1);
      chk("ill_fb_fbdiv", 32'(pll_fbdiv), 100);
      chk("ill_fb_pd",    32'(pll_pd), 1);
      chk("ill_fb_ready", 32'(u_if.cfg_ready), 1);
      cycles(1);
      chk("ill_fb_irq_pulse", 32'(irq), 0);
      chk("ill_fb_err_sticky", 32'(sts_err), 1);

      // Illegal: postdiv1 < postdiv2
      send(1'b0, 12'd200, 6'd2, 3'd1, 3'd2);
      chk("ill_pd_err",   32'(sts_err), 1);
      chk("ill_pd_irq",   32'(irq), 1);
      chk("ill_pd_fbdiv", 32'(pll_fbdiv), 100);
      chk("ill_pd_pdiv1", 32'(pll_postdiv1), 2);

      // Lock never arrives
      send(1'b0, 12'd64, 6'd1, 3'd3, 3'd3);
      chk("to_err_cleared", 32'(sts_err), 0);
      chk("to_fbdiv",       32'(pll_fbdiv), 64);
      n = 0;
      while (pll_pd === 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("to_pd_high_cycles", 32'(n), PD_CYC);
      n = 0;
      while (sts_err !== 1'b1 && n < 600) begin @(negedge clk); n++; end
      chk("to_err_latency", 32'(n), TO_EXP);
      chk("to_irq",     32'(irq), 1);
      chk("to_pd",      32'(pll_pd), 1);
      chk("to_bypass",  32'(pll_bypass), 1);
      chk("to_clk_sel", 32'(clk_sel), 0);
      chk("to_ready",   32'(u_if.cfg_ready), 1);

      // Asynchronous reset while waiting for lock
      send(1'b0, 12'd80, 6'd1, 3'd1, 3'd1);
      n = 0;
      while (pll_pd === 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("mid_pd_low", 32'(pll_pd), 0);
      cycles(5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pd",        32'(pll_pd), 1);
      chk("arst_bypass",    32'(pll_bypass), 1);
      chk("arst_postdivpd", 32'(pll_foutpostdivpd), 1);
      chk("arst_fbdiv",     32'(pll_fbdiv), 50);
      chk("arst_ready",     32'(u_if.cfg_ready), 1);
      chk("arst_clk_sel",   32'(clk_sel), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(5);
      chk("post_rst_pd",    32'(pll_pd), 1);
      chk("post_rst_ready", 32'(u_if.cfg_ready), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
